// File: rtl/button_event_classifier_if.sv
// Bundles the debounced button level with the classified event outputs.
// The master side drives the button level and observes events; the slave
// side is the classifier itself.
interface button_event_classifier_if;
  logic btn_in;
  logic short_press;
  logic long_press;
  logic double_click;
  logic busy;

  modport master (
    output btn_in,
    input  short_press,
    input  long_press,
    input  double_click,
    input  busy
  );

  modport slave (
    input  btn_in,
    output short_press,
    output long_press,
    output double_click,
    output busy
  );
endinterface

// File: rtl/button_event_classifier.sv
// Turns a debounced, synchronous button level into single-cycle event pulses:
// short press, long press (held LONG_T samples) and double click (second press
// within GAP_T low samples of the first release).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a rising edge of the button level
//   PRESS1    | first press in progress, counting high samples
//   LONG_HOLD | long press already reported, waiting for release
//   WAIT_GAP  | first press released, counting low samples for a 2nd press
//   PRESS2    | second press in progress, double click on release
//
// One counter serves both PRESS1 and WAIT_GAP; it is cleared on every state
// transition, so it always measures time spent in the current state.
module button_event_classifier #(
  parameter int LONG_T = 20,  // must be >= 2
  parameter int GAP_T  = 10   // must be >= 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  button_event_classifier_if.slave  bus
);

  localparam int MAX_T = (LONG_T > GAP_T) ? LONG_T : GAP_T;
  localparam int CNT_W = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_T - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_T - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT_GAP  = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic btn_q;
  logic rise;

  logic short_q;
  logic long_q;
  logic double_q;
  logic short_nxt;
  logic long_nxt;
  logic double_nxt;

  // Only the rising edge matters: a fall while idle is ignored and the busy
  // states look at the level directly.
  assign rise = bus.btn_in & ~btn_q;

  // Edge register; resets high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b1;
    end else begin
      btn_q <= bus.btn_in;
    end
  end

  // State, shared counter and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      short_q  <= short_nxt;
      long_q   <= long_nxt;
      double_q <= double_nxt;
    end
  end

  // Next-state, counter and event decode. Level checks take priority over
  // counter expiry so a release on the long-press edge, or a re-press on the
  // gap-expiry edge, follows the level rather than the timer.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end

      PRESS1: begin
        if (!bus.btn_in) begin
          state_nxt = WAIT_GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HOLD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      LONG_HOLD: begin
        if (!bus.btn_in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      WAIT_GAP: begin
        if (bus.btn_in) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      PRESS2: begin
        if (!bus.btn_in) begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          double_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.short_press  = short_q;
  assign bus.long_press   = long_q;
  assign bus.double_click = double_q;
  assign bus.busy         = (state != IDLE);

  // Each press sequence produces one event, so pulses never overlap.
  a_events_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0({short_q, long_q, double_q})
  );

endmodule

// File: doc/button_event_classifier.md
# button_event_classifier

Classifies a clean button level into single-cycle event pulses: short press, long press, and double click. Sits directly downstream of the debouncer stage. It consumes the debounced, already-synchronous level and feeds control logic that needs discrete user events rather than raw levels. It is purely synchronous to `clk` and contains an edge register, a 5-state FSM and one shared cycle counter.

## Interface
- `LONG_T`, default 20: number of consecutive high samples after the press-entry sample that classify a long press. Must be ≥ 2.
- `GAP_T`, default 10: maximum number of low samples after the first release within which a second press counts as a double click. Must be ≥ 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `btn_in`  input  1  debounced button level, synchronous to `clk`; 1 = pressed.
- `short_press`  output  1  registered 1-cycle pulse: single press released before `LONG_T`, with no second press within `GAP_T`.
- `long_press`  output  1  registered 1-cycle pulse: press held for `LONG_T` samples.
- `double_click`  output  1  registered 1-cycle pulse: second press released.
- `busy`  output  1  high whenever FSM state ≠ IDLE; decoded from the state register.

## Operation
- **Edge register `btn_q`**: `btn_q <= btn_in` every cycle.
  - `rise = btn_in & ~btn_q`; `fall = ~btn_in & btn_q`.
- **Counter `cnt`**:
  - Width `$clog2(max(LONG_T,GAP_T))+1`.
  - Cleared on every state transition; increments only where stated below. It never wraps.
- **States and transitions** (outputs default to 0 every cycle):
  - **IDLE**: on `rise` → PRESS1, `cnt<=0`. A `fall` in IDLE is ignored.
  - **PRESS1**:
    - If `!btn_in` → WAIT_GAP, `cnt<=0`.
    - Else if `cnt==LONG_T-1` → LONG_HOLD, `long_press<=1`.
    - Else `cnt<=cnt+1`.
  - **LONG_HOLD**: on `!btn_in` → IDLE. No further pulses, however long the hold.
  - **WAIT_GAP**:
    - If `btn_in` → PRESS2, `cnt<=0`.
    - Else if `cnt==GAP_T-1` → IDLE, `short_press<=1`.
    - Else `cnt<=cnt+1`.
  - **PRESS2**: on `!btn_in` → IDLE, `double_click<=1`. The length of the second press is irrelevant; no long-press check applies.
- **Exclusivity**: at most one of the three event outputs is high in any cycle. Every press sequence yields exactly one event.

## Timing
- **Reset values**:
  - state IDLE, `cnt=0`.
  - `short_press=long_press=double_click=0`, `busy=0`.
  - `btn_q=1`, so a button held through reset release is not a press. It must be released and pressed again.
- **Press entry**: sample edge E with `btn_in=1`, `btn_q=0`. `busy` is high from the cycle after E.
- **long_press latency**: the pulse is high in the cycle following edge E+`LONG_T`. This requires `btn_in=1` at edges E..E+`LONG_T`.
- **Release in PRESS1 at edge F** (first low sample):
  - `short_press` is high in the cycle following edge F+`GAP_T`, provided `btn_in=0` at edges F..F+`GAP_T`.
  - If `btn_in=1` at any edge F+1..F+`GAP_T`, the FSM enters PRESS2.
- **double_click**: high in the cycle following the first low sample in PRESS2.
- **Boundary cases**:
  - A high at exactly edge F+`GAP_T` (the same edge the counter expires) still goes to PRESS2; the `btn_in` check has priority.
  - A release at exactly edge E+`LONG_T` goes to WAIT_GAP, not long press; the release check has priority.
- **Return to IDLE**: `busy` drops in the cycle after the event pulse edge (LONG_HOLD: after the release edge). A new `rise` is accepted from the first IDLE cycle.
- **Asynchronous reset mid-sequence**: all outputs drop immediately; no pending event is emitted after reset.

## Test plan
- **Short press** (`LONG_T`=20, `GAP_T`=10): `btn_in` high 5 cycles, then low → exactly one `short_press` pulse, 10 cycles after the first low sample. No other pulses.
- **Long press**: `btn_in` high 40 cycles → `long_press` pulse 20 cycles after the entry sample. No pulse on release; `busy` drops one cycle after release.
- **Double click**: high 4, low 6, high 3, low → one `double_click` pulse one cycle after the second release. No `short_press`.
- **Gap boundaries**:
  - Low exactly 10 samples before the second rise → PRESS2 path, `double_click`.
  - Low 11 samples → `short_press`, then the second press starts a new sequence.
- **Reset**:
  - Hold `btn_in=1` across `rst_n` deassertion for 50 cycles → no events, `busy=0`.
  - Assert `rst_n` low during PRESS2 → outputs 0 immediately, no `double_click` afterwards.
- **Back-to-back sequences**: run the short press, long press and double click sequences back to back with 1 idle cycle between them → each event seen exactly once, in order. Check every cycle that the three event outputs are mutually exclusive.
